// File: rtl/cfu_simd_pkg.sv
// Shared types and constants for the SIMD lane / MAC custom function unit.
package cfu_simd_pkg;

    // Field positions inside cmd_payload_function_id
    localparam int unsigned OP_LSB   = 0;
    localparam int unsigned OP_MSB   = 2;
    localparam int unsigned SIGN_BIT = 3;

    typedef enum logic [2:0] {
        OP_LSUM  = 3'd0,
        OP_LSWAP = 3'd1,
        OP_BREV  = 3'd2,
        OP_MAC   = 3'd3,
        OP_RDACC = 3'd4,
        OP_WRACC = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MAC  = 1'b1
    } state_e;

    // Number of lanes packed into a 32-bit operand
    function automatic int unsigned lanes_of(int unsigned lane_w);
        return 32 / lane_w;
    endfunction

endpackage

// File: rtl/cfu_lane_mul.sv
// Single LANE_W x LANE_W multiplier producing an ACC_W-bit extended product.
module cfu_lane_mul #(
    parameter int unsigned LANE_W = 8,
    parameter int unsigned ACC_W  = 32
) (
    input  logic              sgn,
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [ACC_W-1:0]  prod
);

    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;

    // Extend both operands to ACC_W first; the low ACC_W bits of the
    // product are then exact for both signed and unsigned modes.
    always_comb begin
        a_ext = {{(ACC_W-LANE_W){sgn & a[LANE_W-1]}}, a};
        b_ext = {{(ACC_W-LANE_W){sgn & b[LANE_W-1]}}, b};
        prod  = a_ext * b_ext;
    end

endmodule

// File: rtl/cfu_simd_mac.sv
// CFU with parametrised lane ops, a persistent accumulator and an
// iterative one-lane-per-cycle dot-product MAC, with registered response.
module cfu_simd_mac
    import cfu_simd_pkg::*;
#(
    parameter int unsigned LANE_W = 8,
    parameter int unsigned ACC_W  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_payload_response_ok,
    output logic [31:0] rsp_payload_outputs_0
);

    localparam int unsigned LANES = lanes_of(LANE_W);
    localparam int unsigned CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  lane_cnt;
    logic [31:0]       a_q, b_q;
    logic              sgn_q;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              rsp_valid_q, rsp_ok_q;
    logic [31:0]       rsp_out_q;

    op_e               op;
    logic              sgn_in;
    logic              drain_ok, accept, mac_last, mac_done, load_rsp;
    logic [LANE_W-1:0] lane_a, lane_b;
    logic [ACC_W-1:0]  prod, mac_sum;
    logic              res_ok;
    logic [31:0]       res_val, rsp_d;
    logic [63:0]       acc_wide;
    logic              unused_fid;

    assign op         = op_e'(cmd_payload_function_id[OP_MSB:OP_LSB]);
    assign sgn_in     = cmd_payload_function_id[SIGN_BIT];
    assign unused_fid = ^cmd_payload_function_id[9:4];

    function automatic logic [31:0] ext32(input logic [LANE_W-1:0] v, input logic s);
        return {{(32-LANE_W){s & v[LANE_W-1]}}, v};
    endfunction

    // Handshake decode and next-state selection
    always_comb begin
        state_d   = state_q;
        drain_ok  = !rsp_valid_q || rsp_ready;
        cmd_ready = (state_q == S_IDLE) && drain_ok;
        accept    = cmd_valid && cmd_ready;
        mac_last  = (state_q == S_MAC) && (lane_cnt == LAST_LANE);
        mac_done  = mac_last && drain_ok;
        load_rsp  = (accept && (op != OP_MAC)) || mac_done;
        case (state_q)
            S_IDLE:  if (accept && (op == OP_MAC)) state_d = S_MAC;
            S_MAC:   if (mac_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Select the latched operand lanes for the current MAC step
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (32'(lane_cnt) == i) begin
                lane_a = a_q[i*LANE_W +: LANE_W];
                lane_b = b_q[i*LANE_W +: LANE_W];
            end
        end
    end

    cfu_lane_mul #(
        .LANE_W (LANE_W),
        .ACC_W  (ACC_W)
    ) u_mul (
        .sgn  (sgn_q),
        .a    (lane_a),
        .b    (lane_b),
        .prod (prod)
    );

    // Single-cycle op results and accumulator update
    always_comb begin
        res_ok   = 1'b1;
        res_val  = '0;
        acc_d    = acc_q;
        acc_wide = 64'(acc_q);
        mac_sum  = acc_q + prod;
        if (accept) begin
            unique case (op)
                OP_LSUM: begin
                    for (int unsigned i = 0; i < LANES; i++) begin
                        res_val = res_val
                                + ext32(cmd_payload_inputs_0[i*LANE_W +: LANE_W], sgn_in)
                                + ext32(cmd_payload_inputs_1[i*LANE_W +: LANE_W], sgn_in);
                    end
                end
                OP_LSWAP: begin
                    for (int unsigned i = 0; i < LANES; i++) begin
                        res_val[(LANES-1-i)*LANE_W +: LANE_W] = cmd_payload_inputs_0[i*LANE_W +: LANE_W];
                    end
                end
                OP_BREV: begin
                    for (int unsigned i = 0; i < 32; i++) begin
                        res_val[31-i] = cmd_payload_inputs_0[i];
                    end
                end
                OP_MAC: begin
                    res_val = '0;
                end
                OP_RDACC: begin
                    res_val = ((ACC_W == 64) && cmd_payload_inputs_1[0]) ? acc_wide[63:32] : acc_wide[31:0];
                end
                OP_WRACC: begin
                    res_val = acc_wide[31:0];
                    acc_d   = ACC_W'(cmd_payload_inputs_0);
                end
                default: begin
                    res_ok = 1'b0;
                end
            endcase
        end else if ((state_q == S_MAC) && (!mac_last || drain_ok)) begin
            // The last lane's add is deferred with the stall so it lands exactly once
            acc_d = mac_sum;
        end
        rsp_d = mac_done ? mac_sum[31:0] : res_val;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Operand latch, lane counter, accumulator and response register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q         <= '0;
            b_q         <= '0;
            sgn_q       <= 1'b0;
            lane_cnt    <= '0;
            acc_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_ok_q    <= 1'b1;
            rsp_out_q   <= '0;
        end else begin
            if (accept) begin
                a_q      <= cmd_payload_inputs_0;
                b_q      <= cmd_payload_inputs_1;
                sgn_q    <= sgn_in;
                lane_cnt <= '0;
            end else if ((state_q == S_MAC) && !mac_last) begin
                lane_cnt <= lane_cnt + CNT_W'(1);
            end
            acc_q <= acc_d;
            if (load_rsp) begin
                rsp_valid_q <= 1'b1;
                rsp_ok_q    <= res_ok;
                rsp_out_q   <= rsp_d;
            end else if (rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid               = rsp_valid_q;
    assign rsp_payload_response_ok = rsp_ok_q;
    assign rsp_payload_outputs_0   = rsp_out_q;

endmodule

// File: tb/tb_cfu_simd_mac.sv
// Self-checking bench for cfu_simd_mac: directed cases plus randomized ops
// checked against a lane-arithmetic reference model and a response queue.
`timescale 1ns/1ps
module tb_cfu_simd_mac;

    localparam int LW = 8;
    localparam int AW = 32;
    localparam int NL = 32 / LW;

    typedef struct {
        logic        ok;
        logic [31:0] val;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  fid;
    logic [31:0] in0, in1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_ok;
    logic [31:0] rsp_out;

    cfu_simd_mac #(.LANE_W(LW), .ACC_W(AW)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (fid),
        .cmd_payload_inputs_0    (in0),
        .cmd_payload_inputs_1    (in1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_response_ok (rsp_ok),
        .rsp_payload_outputs_0   (rsp_out)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t q[$];
    logic [63:0] acc_m = '0;
    bit   rr_rand = 1'b0;
    logic rr_fix  = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Lane i of x as an integer, sign-interpreted when s is set
    function automatic longint lane_s(input logic [31:0] x, input int i, input bit s);
        longint v;
        v = longint'((x >> (i*LW)) & ((32'd1 << LW) - 32'd1));
        if (s && v >= (longint'(1) << (LW-1))) v = v - (longint'(1) << LW);
        return v;
    endfunction

    // Reference behaviour of one accepted command; updates the model accumulator
    function automatic exp_t model_step(input logic [2:0] op, input bit s,
                                        input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sum;
        logic [63:0] mask;
        mask  = (AW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        e.ok  = 1'b1;
        e.val = '0;
        e.due = 0;
        sum   = 0;
        case (op)
            3'd0: begin
                for (int i = 0; i < NL; i++) sum += lane_s(a, i, s) + lane_s(b, i, s);
                e.val = 32'(sum);
            end
            3'd1: for (int i = 0; i < NL; i++) e.val |= 32'(lane_s(a, i, 1'b0)) << ((NL-1-i)*LW);
            3'd2: for (int i = 0; i < 32; i++) e.val[31-i] = a[i];
            3'd3: begin
                for (int i = 0; i < NL; i++) sum += lane_s(a, i, s) * lane_s(b, i, s);
                acc_m = (acc_m + 64'(sum)) & mask;
                e.val = acc_m[31:0];
            end
            3'd4: e.val = (AW == 64 && b[0]) ? acc_m[63:32] : acc_m[31:0];
            3'd5: begin
                e.val = acc_m[31:0];
                acc_m = 64'(a);
            end
            default: e.ok = 1'b0;
        endcase
        return e;
    endfunction

    // Offer one command; returns the model expectation and the accept edge index
    task automatic issue(input logic [2:0] op, input bit s, input logic [31:0] a,
                         input logic [31:0] b, output exp_t e, output int k);
        bit done;
        done = 1'b0;
        k    = -1;
        e    = '{1'b0, 32'd0, 0};
        @(negedge clk);
        cmd_valid = 1'b1;
        fid       = {6'($urandom), s, op};
        in0       = a;
        in1       = b;
        for (int t = 0; t < 200 && !done; t++) begin
            #1;
            if (cmd_ready) begin
                k     = cyc + 1;
                e     = model_step(op, s, a, b);
                e.due = k + ((op == 3'd3) ? NL : 0);
                q.push_back(e);
                done  = 1'b1;
            end
            @(posedge clk);
            if (!done) @(negedge clk);
        end
        #1 cmd_valid = 1'b0;
        if (!done) begin
            n_chk++;
            n_err++;
            $display("FAIL issue_timeout: cmd_ready stayed 0, want 1 for op %0d", op);
        end
    endtask

    // Response-side ready driver
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(negedge clk);
            rsp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_fix;
        end
    end

    // Compare every new response against the queue; held responses must stay stable
    exp_t cur_e = '{1'b0, 32'd0, 0};
    bit   held  = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                held = 1'b0;
            end else if (rsp_valid) begin
                if (!held) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL rsp_unexpected: got response 0x%08h, want none", rsp_out);
                    end else begin
                        cur_e = q.pop_front();
                        chk("rsp_ok", 32'(rsp_ok), 32'(cur_e.ok));
                        chk("rsp_val", rsp_out, cur_e.val);
                        chk("rsp_latency", 32'(cyc), 32'(cur_e.due));
                    end
                end else begin
                    chk("hold_ok", 32'(rsp_ok), 32'(cur_e.ok));
                    chk("hold_val", rsp_out, cur_e.val);
                end
                held = !rsp_ready;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   k, k1, k2;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        fid       = '0;
        in0       = '0;
        in1       = '0;

        #12;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_ok", 32'(rsp_ok), 32'd1);
        chk("reset_outputs", rsp_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);

        // Lane ops
        issue(3'd0, 1'b0, 32'h01020304, 32'h10203040, e, k);
        chk("lit_lsum_u", e.val, 32'h000000AA);
        issue(3'd0, 1'b1, 32'hFFFFFFFF, 32'h00000000, e, k);
        chk("lit_lsum_s", e.val, 32'hFFFFFFFC);
        issue(3'd1, 1'b0, 32'h11223344, 32'h0, e, k1);
        chk("lit_lswap", e.val, 32'h44332211);
        issue(3'd2, 1'b0, 32'h00000001, 32'h0, e, k2);
        chk("lit_brev", e.val, 32'h80000000);
        chk("b2b_accept_gap", 32'(k2 - k1), 32'd1);

        // Accumulator and MAC
        issue(3'd5, 1'b0, 32'h0, 32'h0, e, k);
        issue(3'd3, 1'b1, 32'h01020304, 32'h01010101, e, k);
        chk("lit_mac1", e.val, 32'h0000000A);
        for (int i = 0; i < NL; i++) begin
            @(negedge clk);
            #1 chk("mac_cmd_ready_low", 32'(cmd_ready), 32'd0);
        end
        issue(3'd3, 1'b1, 32'hFFFFFFFF, 32'h01010101, e, k);
        chk("lit_mac2", e.val, 32'h00000006);
        issue(3'd4, 1'b0, 32'h0, 32'h0, e, k);
        chk("lit_rdacc", e.val, 32'h00000006);
        issue(3'd5, 1'b0, 32'hDEADBEEF, 32'h0, e, k);
        chk("lit_wracc_old", e.val, 32'h00000006);
        issue(3'd4, 1'b0, 32'h0, 32'h0, e, k);
        chk("lit_rdacc2", e.val, 32'hDEADBEEF);
        issue(3'd6, 1'b1, 32'h12345678, 32'h9ABCDEF0, e, k);
        chk("lit_rsv_ok", 32'(e.ok), 32'd0);
        chk("lit_rsv_val", e.val, 32'd0);
        issue(3'd4, 1'b0, 32'h0, 32'h0, e, k);
        chk("lit_rdacc3", e.val, 32'hDEADBEEF);

        // Backpressure: hold a result for three cycles
        repeat (2) @(negedge clk);
        #1 rr_fix = 1'b0;
        issue(3'd0, 1'b0, 32'h01020304, 32'h10203040, e, k);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rr_fix = 1'b1;

        // MAC issued right behind a result, then its own result held under backpressure
        issue(3'd0, 1'b1, 32'h80808080, 32'h7F7F7F7F, e, k);
        issue(3'd3, 1'b0, 32'hFF10FF20, 32'h0302FF01, e, k);
        rr_fix = 1'b0;
        repeat (NL + 3) @(negedge clk);
        #1 rr_fix = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the middle of a MAC
        issue(3'd3, 1'b1, 32'h7F7F7F7F, 32'h7F7F7F7F, e, k);
        @(negedge clk);
        @(negedge clk);
        #3 reset = 1'b0;
        #1;
        chk("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_reset_outputs", rsp_out, 32'd0);
        chk("mid_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        q.delete();
        acc_m = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        issue(3'd4, 1'b0, 32'h0, 32'h0, e, k);
        chk("lit_rdacc_after_reset", e.val, 32'h0);

        // Randomized ops with random backpressure
        rr_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, $urandom, e, k);
        end
        rr_rand = 1'b0;
        rr_fix  = 1'b1;
        for (int t = 0; t < 100 && (q.size() != 0 || rsp_valid); t++) @(negedge clk);
        @(negedge clk);
        #3 chk("queue_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
